cmd_rsp: RTL
============

CMD_RSP -- requirements
Module: cmd_rsp

Interface
REQ-001 The block SHALL have parameter P_DEPTH, default 4: response FIFO depth in entries, a power of two of at least 2.
REQ-002 The block SHALL have parameter P_TIMEOUT, default 16'h1000: maximum number of cycles the block waits in one active state, nonzero.
REQ-003 The block SHALL have parameter P_ACK_RSP, default 8'hA5: the response byte pushed when ACK is accepted.
REQ-004 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_type  in  8  command code from the initiator: 00 IDLE, 80 START, 20 READ, 40 WRITE, FF ACK.
- clk_cnt  in  16  initiator cycle count, sampled on WRITE.
- rsp_ready  in  1  downstream accepts the response.
- err_clr  in  1  single-cycle clear of err_code.
- rsp_valid  out  1  response FIFO is not empty.
- rsp_data  out  8  head entry of the response FIFO.
- busy  out  1  state is not R_IDLE.
- state  out  3  R_IDLE=0, R_START=1, R_READ=2, R_WRITE=3, R_ACK=4.
- seq_done  out  1  one-cycle pulse when ACK is accepted.
- err_code  out  3  sticky error flags: [0] illegal transition, [1] timeout, [2] overflow.

Function
REQ-005 The block SHALL register cmd_type into cmd_q every cycle; an event is a clock edge where cmd_type != cmd_q.
REQ-006 The block SHALL take the following actions on an event, keyed on the current state and the new code. Each push writes one FIFO entry at that edge.
- R_IDLE, 80: go to R_START, push 8'h81.
- R_START, 20: go to R_READ, push rd_seq, then rd_seq+1 (8-bit counter, wraps FF to 00).
- R_READ, 40: go to R_WRITE, push clk_cnt[7:0] as sampled at that edge.
- R_WRITE, FF: go to R_ACK, push P_ACK_RSP, and assert seq_done the following cycle.
- R_ACK, 00: go to R_IDLE, no push.
- R_ACK, 80: go to R_START, push 8'h81.
REQ-007 Any other event SHALL be treated as illegal: no push, state goes to R_IDLE, err_code[0] is set. This includes unknown codes and a return to 00 from R_START, R_READ or R_WRITE.
REQ-008 cmd_type holding the same value SHALL cause no action, including repeated 00 in R_IDLE.
REQ-009 A dwell counter (16 bit) SHALL clear on every event and while the state is R_IDLE or R_ACK, and SHALL increment every cycle otherwise.
REQ-010 When the dwell counter equals P_TIMEOUT-1 with no event that cycle, the next edge SHALL set err_code[1], go to R_IDLE, and clear the counter. If an event and a timeout coincide, the event wins.
REQ-011 The FIFO SHALL be P_DEPTH entries with binary read and write pointers and an occupancy count.
- rsp_valid = count != 0.
- rsp_data = head entry.
- A pop occurs when rsp_valid && rsp_ready.
REQ-012 rsp_data SHALL hold stable while rsp_valid && !rsp_ready.
REQ-013 Push latency SHALL be 1: a push at edge N makes rsp_valid high after edge N when the FIFO was empty.
REQ-014 Push while full without a pop SHALL drop the entry and set err_code[2]. The state transition still occurs.
REQ-015 Push while full with a pop in the same cycle SHALL be accepted; the count stays at P_DEPTH.
REQ-016 Simultaneous push and pop on an empty FIFO is impossible (rsp_valid is 0), so no bypass path exists.
REQ-017 Pointers SHALL wrap modulo P_DEPTH.
REQ-018 err_code bits SHALL be sticky and OR in new errors. err_clr clears all bits, but an error raised in the same cycle as err_clr survives.
REQ-019 seq_done SHALL be exactly one cycle wide per accepted ACK.

Reset
REQ-020 While reset is high, the block SHALL asynchronously force:
- state to R_IDLE and cmd_q to 8'h00;
- rd_seq, the dwell counter and the FIFO pointers and count to 0;
- rsp_valid, seq_done and busy to 0;
- err_code to 3'b000 and rsp_data to 8'h00.
REQ-021 Reset asserted mid-sequence SHALL discard all FIFO contents. After release, the first event is evaluated against cmd_q = 00 and state R_IDLE.

Verification
REQ-022 Full sequence: cmd 00→80→20→40 (clk_cnt=16'h0040)→FF→00, rsp_ready=1. Required: responses 81, 00, 40, A5 in order; one seq_done pulse; err_code=000; final state R_IDLE.
REQ-023 Illegal transition: from R_START drive cmd 40. Required: no push, err_code=001, state R_IDLE. Then err_clr → err_code=000.
REQ-024 Timeout: with P_TIMEOUT=16, drive 80 and hold. Required: 16 cycles after entering R_START, state R_IDLE and err_code=010.
REQ-025 Overflow: P_DEPTH=2, rsp_ready=0, run two full sequences. Required: FIFO holds 81, 00; err_code[2] set; the rd_seq response of the second sequence is 01.
REQ-026 Full with simultaneous pop: with the FIFO full, push and pop in the same cycle. Required: count stays 2, no overflow; rsp_data holds stable during rsp_ready=0 stalls.
REQ-027 Reset in R_WRITE with 3 entries queued. Required: rsp_valid=0 and state R_IDLE immediately; the next sequence's READ response is 00.

Source files
------------

// File: rtl/cmd_rsp.sv
// Command/response sequencer: tracks the initiator's command code, queues the
// response bytes in a small FIFO and flags illegal transitions, timeouts and overflows.
module cmd_rsp #(
  parameter int          P_DEPTH   = 4,
  parameter logic [15:0] P_TIMEOUT = 16'h1000,
  parameter logic [7:0]  P_ACK_RSP = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cmd_type,
  input  logic [15:0] clk_cnt,
  input  logic        rsp_ready,
  input  logic        err_clr,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic [2:0]  state,
  output logic        seq_done,
  output logic [2:0]  err_code
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] R_IDLE  = 3'd0;
  localparam logic [2:0] R_START = 3'd1;
  localparam logic [2:0] R_READ  = 3'd2;
  localparam logic [2:0] R_WRITE = 3'd3;
  localparam logic [2:0] R_ACK   = 3'd4;

  logic [7:0]    cmd_q;
  logic [7:0]    rd_seq;
  logic [15:0]   dwell;
  logic [2:0]    state_d;
  logic [7:0]    mem [P_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic       evt, legal, illegal, active, timeout;
  logic       push, push_ok, pop, full, ovf, rd_inc, ack;
  logic [7:0] push_data;

  // Only the low byte of the initiator count is ever reported.
  logic unused_cnt_hi;
  assign unused_cnt_hi = ^clk_cnt[15:8];

  assign evt     = cmd_type != cmd_q;
  assign active  = (state == R_START) || (state == R_READ) || (state == R_WRITE);
  assign timeout = active && !evt && (dwell == P_TIMEOUT - 16'd1);

  always_comb begin
    state_d   = state;
    legal     = 1'b0;
    push      = 1'b0;
    push_data = '0;
    rd_inc    = 1'b0;
    ack       = 1'b0;
    if (evt) begin
      case (state)
        R_IDLE:
          if (cmd_type == 8'h80) begin
            legal = 1'b1; state_d = R_START; push = 1'b1; push_data = 8'h81;
          end
        R_START:
          if (cmd_type == 8'h20) begin
            legal = 1'b1; state_d = R_READ; push = 1'b1; push_data = rd_seq; rd_inc = 1'b1;
          end
        R_READ:
          if (cmd_type == 8'h40) begin
            legal = 1'b1; state_d = R_WRITE; push = 1'b1; push_data = clk_cnt[7:0];
          end
        R_WRITE:
          if (cmd_type == 8'hFF) begin
            legal = 1'b1; state_d = R_ACK; push = 1'b1; push_data = P_ACK_RSP; ack = 1'b1;
          end
        R_ACK:
          if (cmd_type == 8'h00) begin
            legal = 1'b1; state_d = R_IDLE;
          end else if (cmd_type == 8'h80) begin
            legal = 1'b1; state_d = R_START; push = 1'b1; push_data = 8'h81;
          end
        default: ;
      endcase
      if (!legal) state_d = R_IDLE;
    end else if (timeout) begin
      state_d = R_IDLE;
    end
  end

  assign illegal = evt && !legal;

  assign rsp_valid = count != '0;
  assign rsp_data  = rsp_valid ? mem[rd_ptr] : '0;
  assign busy      = state != R_IDLE;
  assign pop       = rsp_valid && rsp_ready;
  assign full      = count == CW'(P_DEPTH);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push_ok   = push && (!full || pop);
  assign ovf       = push && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= R_IDLE;
      cmd_q    <= '0;
      rd_seq   <= '0;
      dwell    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq_done <= 1'b0;
      err_code <= '0;
    end else begin
      cmd_q    <= cmd_type;
      state    <= state_d;
      seq_done <= ack;
      err_code <= (err_clr ? 3'b000 : err_code) | {ovf, timeout, illegal};
      if (rd_inc) rd_seq <= rd_seq + 8'd1;
      if (evt || !active || timeout) dwell <= '0;
      else                           dwell <= dwell + 16'd1;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule
